// File: rtl/dpr_sync_be.sv
// dpr_sync_be: synchronous dual-port RAM with byte enables, read-during-write modes, optional output register and post-reset clear
module dpr_sync_be #(
    parameter int MEM_WIDTH    = 16,
    parameter int MEM_DEPTH    = 1024,
    parameter int ADDR_SIZE    = 10,
    parameter int BE_WIDTH     = MEM_WIDTH / 8,
    parameter int RD_MODE      = 0,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 blk_select,
    input  logic                 wr_en,
    input  logic [BE_WIDTH-1:0]  wr_be,
    input  logic [ADDR_SIZE-1:0] addr_wr,
    input  logic [MEM_WIDTH-1:0] din,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] addr_rd,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 rd_valid,
    output logic                 collision,
    output logic                 busy
);
    localparam int IDX = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [IDX-1:0] LAST = IDX'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;

    state_t               state, state_next;
    logic [IDX-1:0]       cnt;
    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
    logic                 ready, wr_acc, rd_acc, hit, rd_in_range;
    logic [MEM_WIDTH-1:0] old_word, merged, rd_word;
    logic                 v1, c1;
    logic [MEM_WIDTH-1:0] d1;

    assign busy = state != READY;

    // state register and clear-sweep address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == CLEAR) ? cnt + 1'b1 : '0;
        end
    end

    // next state: optional zeroing sweep after reset, then ready until the next reset
    always_comb begin
        state_next = state;
        if (state == RESET)
            state_next = (CLEAR_ON_RST != 0) ? CLEAR : READY;
        else if (state == CLEAR && cnt == LAST)
            state_next = READY;
    end

    // request qualification and read word, with write-first bypass on a same-address hit
    always_comb begin
        ready       = state == READY && !rst;
        wr_acc      = ready && blk_select && wr_en && |wr_be && ({1'b0, addr_wr} < DEPTH);
        rd_acc      = ready && blk_select && rd_en;
        rd_in_range = {1'b0, addr_rd} < DEPTH;
        hit         = wr_acc && addr_wr == addr_rd;
        old_word    = rd_in_range ? mem[addr_rd[IDX-1:0]] : '0;
        merged      = old_word;
        for (int i = 0; i < BE_WIDTH; i++)
            if (wr_be[i]) merged[8*i +: 8] = din[8*i +: 8];
        rd_word     = (RD_MODE != 0 && hit) ? merged : old_word;
    end

    // array update: the clear sweep owns the array, otherwise byte-masked writes
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[cnt] <= '0;
        else if (wr_acc)
            for (int i = 0; i < BE_WIDTH; i++)
                if (wr_be[i]) mem[addr_wr[IDX-1:0]][8*i +: 8] <= din[8*i +: 8];
    end

    // first read stage: data only moves on an accepted read so the output holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            c1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_acc;
            c1 <= rd_acc && hit;
            if (rd_acc) d1 <= rd_word;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                 v2, c2;
        logic [MEM_WIDTH-1:0] d2;
        // second stage: advances only behind a valid first-stage word
        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= 1'b0;
                c2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                c2 <= c1;
                if (v1) d2 <= d1;
            end
        end
        assign dout      = d2;
        assign rd_valid  = v2;
        assign collision = c2;
    end else begin : g_no_reg
        assign dout      = d1;
        assign rd_valid  = v1;
        assign collision = c1;
    end
endmodule
